sel4_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4:1 single-bit select path between four requesters.
- Registers a grant, drives the 2-bit select code, and presents the selected requester's data bit on a shared output.
- Sits in front of the 4:1 selector. Requester i owns din[i]. Downstream logic samples dout while valid is high.

---
 rtl/sel4_rr_arbiter_pkg.sv | 26 ++
 rtl/sel4_rr_arbiter_if.sv | 20 ++
 rtl/mux4.sv | 16 +
 rtl/sel4_rr_arbiter_pick.sv | 32 +++
 rtl/sel4_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_sel4_rr_arbiter.sv | 206 ++++++++++++++++++++
 6 files changed

// File: rtl/sel4_rr_arbiter_pkg.sv
// ============================================================================
// sel4_rr_arbiter_pkg
//   Shared state encoding, select codes and one-hot helper for the arbiter.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package sel4_rr_arbiter_pkg;

  typedef logic [1:0] code_t;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam code_t SEL_R0 = 2'h0;
  localparam code_t SEL_R1 = 2'h1;
  localparam code_t SEL_R2 = 2'h2;
  localparam code_t SEL_R3 = 2'h3;

  function automatic logic [3:0] onehot4(input code_t code);
    onehot4 = 4'b0001 << code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sel4_rr_arbiter_if.sv
// ============================================================================
// sel4_rr_arbiter_if
//   Request/grant/data bundle between four requesters and the arbiter.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface sel4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       dout;

  modport master (output req, output din, input gnt, input sel, input valid, input dout);
  modport slave  (input req, input din, output gnt, output sel, output valid, output dout);
endinterface

`default_nettype wire

// File: rtl/mux4.sv
// ============================================================================
// mux4
//   Single-bit 4-to-1 selector.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mux4 (
  input  wire logic [3:0] d,
  input  wire logic [1:0] s,
  output      logic       y
);
  assign y = d[s];
endmodule

`default_nettype wire

// File: rtl/sel4_rr_arbiter_pick.sv
// ============================================================================
// sel4_rr_pick
//   Combinational round-robin search: first set req at start, start+1, ...
//   (mod 4), never choosing the index given by exclude.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sel4_rr_pick
  import sel4_rr_arbiter_pkg::*;
(
  input  wire logic [3:0] req,
  input  wire code_t      start,
  input  wire code_t      exclude,
  output      logic       found,
  output      code_t      idx
);

  always_comb begin
    found = 1'b0;
    idx   = start;
    for (int k = 0; k < 4; k++) begin
      if (!found && req[start + 2'(k)] && ((start + 2'(k)) != exclude)) begin
        found = 1'b1;
        idx   = start + 2'(k);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sel4_rr_arbiter.sv
// ============================================================================
// sel4_rr_arbiter
//   Round-robin owner of a shared 4:1 single-bit select path.
//   Optional max-hold preemption: define SEL4_RR_ARBITER_TIMEOUT_EN.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sel4_rr_arbiter
  import sel4_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 4
) (
  input wire logic          clk,
  input wire logic          rst,
  sel4_rr_arbiter_if.slave  bus
);

  if ((MAX_HOLD < 2) || (MAX_HOLD > 15) || ((2 ** CW) <= MAX_HOLD)) begin : g_bad_cfg
    $error("sel4_rr_arbiter: illegal MAX_HOLD/CW combination");
  end

  logic [0:0] state;
  logic [3:0] gnt;
  code_t      sel;
  code_t      ptr;

  logic       pick_found;
  code_t      pick_idx;
  code_t      pick_start;
  logic       win_found;
  code_t      win_idx;
  logic       do_grant;
  logic       go_idle;
  code_t      grant_idx;
  logic       mux_out;

`ifdef SEL4_RR_ARBITER_TIMEOUT_EN
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
  logic [CW-1:0] cnt;
  logic          hold_done;
  assign hold_done = (cnt == HOLD_LAST);
`endif

  // In BUSY ptr equals the owner, so one search serves both the idle scan
  // (ptr is checked last, below) and the handover scan that skips the owner.
  assign pick_start = ptr + 2'd1;

  sel4_rr_pick u_pick (
    .req     (bus.req),
    .start   (pick_start),
    .exclude (ptr),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  assign win_found = pick_found | bus.req[ptr];
  assign win_idx   = pick_found ? pick_idx : ptr;

  always_comb begin
    do_grant  = 1'b0;
    go_idle   = 1'b0;
    grant_idx = pick_idx;
    case (state)
      IDLE: begin
        if (win_found) begin
          do_grant  = 1'b1;
          grant_idx = win_idx;
        end
      end
      BUSY: begin
        if (!bus.req[sel]) begin
          if (pick_found) do_grant = 1'b1;
          else            go_idle  = 1'b1;
        end
`ifdef SEL4_RR_ARBITER_TIMEOUT_EN
        else if (hold_done && pick_found) begin
          do_grant = 1'b1;
        end
`endif
      end
      default: go_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 4'h0;
      sel   <= SEL_R0;
      ptr   <= SEL_R3;
`ifdef SEL4_RR_ARBITER_TIMEOUT_EN
      cnt   <= '0;
`endif
    end else if (do_grant) begin
      state <= BUSY;
      gnt   <= onehot4(grant_idx);
      sel   <= grant_idx;
      ptr   <= grant_idx;
`ifdef SEL4_RR_ARBITER_TIMEOUT_EN
      cnt   <= '0;
`endif
    end else if (go_idle) begin
      state <= IDLE;
      gnt   <= 4'h0;
      sel   <= SEL_R0;
    end
`ifdef SEL4_RR_ARBITER_TIMEOUT_EN
    // Saturate rather than wrap so a lone owner is preempted as soon as
    // someone else shows up.
    else if ((state == BUSY) && !hold_done) begin
      cnt <= cnt + 1'b1;
    end
`endif
  end

  mux4 u_mux (
    .d (bus.din),
    .s (sel),
    .y (mux_out)
  );

  assign bus.gnt   = gnt;
  assign bus.sel   = sel;
  assign bus.valid = |gnt;
  assign bus.dout  = (|gnt) & mux_out;

endmodule

`default_nettype wire

// File: tb/tb_sel4_rr_arbiter.sv
// ============================================================================
// tb_sel4_rr_arbiter
//   Directed self-checking bench for sel4_rr_arbiter.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sel4_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  sel4_rr_arbiter_if bus ();

  sel4_rr_arbiter #(.MAX_HOLD(8), .CW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = 4'h0;
    @(negedge clk);
    rst     = 1'b0;
  endtask

  // {gnt, sel, valid}
  function automatic logic [6:0] owner_vec(input int o);
    logic [3:0] g;
    g = 4'b0001 << o;
    return {g, 2'(o), 1'b1};
  endfunction

  task automatic test_reset();
    bus.req = 4'h0;
    bus.din = 4'hF;
    #1;
    total++; if (bus.gnt !== 4'h0) $display("FAIL reset_gnt: got %h want 0", bus.gnt); else passed++;
    total++; if (bus.sel !== 2'h0) $display("FAIL reset_sel: got %h want 0", bus.sel); else passed++;
    total++; if (bus.valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.valid); else passed++;
    total++; if (bus.dout !== 1'b0) $display("FAIL reset_dout: got %b want 0", bus.dout); else passed++;
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 4'b0100;
    bus.din = 4'b0100;
    step();
    total++; if ({bus.gnt, bus.sel, bus.valid} !== 7'b0100_10_1)
      $display("FAIL single_grant: got %h/%h/%b want 4/2/1", bus.gnt, bus.sel, bus.valid); else passed++;
    total++; if (bus.dout !== 1'b1) $display("FAIL single_dout: got %b want 1", bus.dout); else passed++;
    bus.din = 4'b1011;
    #1;
    total++; if (bus.dout !== 1'b0) $display("FAIL single_dout_owner_only: got %b want 0", bus.dout); else passed++;
    bus.req = 4'h0;
    step();
    total++; if ({bus.gnt, bus.valid, bus.dout} !== 6'b0000_0_0)
      $display("FAIL single_release: got %h/%b/%b want 0/0/0", bus.gnt, bus.valid, bus.dout); else passed++;
    // last owner 2: scan 3,0,1,2 picks requester 0
    bus.req = 4'b0101;
    step();
    total++; if ({bus.gnt, bus.sel, bus.valid} !== owner_vec(0))
      $display("FAIL single_ptr_after_release: got %h/%h want 1/0", bus.gnt, bus.sel); else passed++;
    bus.req = 4'h0;
    step();
  endtask

  task automatic test_rr_order();
    int prev;
    do_reset();
    bus.din = 4'h0;
    bus.req = 4'hF;
    step();
    total++; if ({bus.gnt, bus.sel, bus.valid} !== owner_vec(0))
      $display("FAIL rr_first: got %h/%h/%b want owner 0", bus.gnt, bus.sel, bus.valid); else passed++;
    step();
    total++; if ({bus.gnt, bus.sel, bus.valid} !== owner_vec(0))
      $display("FAIL rr_hold0: got %h/%h/%b want owner 0", bus.gnt, bus.sel, bus.valid); else passed++;
    prev = 0;
    for (int k = 1; k <= 4; k++) begin
      bus.req = 4'hF & ~(4'b0001 << prev);
      step();
      total++; if ({bus.gnt, bus.sel, bus.valid} !== owner_vec(k % 4))
        $display("FAIL rr_handover_%0d: got %h/%h/%b want owner %0d", k, bus.gnt, bus.sel, bus.valid, k % 4); else passed++;
      bus.req = 4'hF;
      step();
      total++; if ({bus.gnt, bus.sel, bus.valid} !== owner_vec(k % 4))
        $display("FAIL rr_keep_%0d: got %h/%h/%b want owner %0d", k, bus.gnt, bus.sel, bus.valid, k % 4); else passed++;
      prev = k % 4;
    end
    bus.req = 4'h0;
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    bus.req = 4'b1000;
    step();
    total++; if ({bus.gnt, bus.sel, bus.valid} !== owner_vec(3))
      $display("FAIL wrap_owner3: got %h/%h want 8/3", bus.gnt, bus.sel); else passed++;
    bus.req = 4'b0000;
    step();
    bus.req = 4'b1001;
    step();
    total++; if ({bus.gnt, bus.sel, bus.valid} !== owner_vec(0))
      $display("FAIL wrap_idle: got %h/%h want 1/0", bus.gnt, bus.sel); else passed++;
    bus.req = 4'b1000;
    step();
    total++; if ({bus.gnt, bus.sel, bus.valid} !== owner_vec(3))
      $display("FAIL wrap_to3: got %h/%h want 8/3", bus.gnt, bus.sel); else passed++;
    bus.req = 4'b0001;
    step();
    total++; if ({bus.gnt, bus.sel, bus.valid} !== owner_vec(0))
      $display("FAIL wrap_handover: got %h/%h want 1/0", bus.gnt, bus.sel); else passed++;
    bus.req = 4'h0;
    step();
  endtask

  task automatic test_timeout();
    int exp_o;
    int errs;
    do_reset();
    bus.din = 4'h0;
    bus.req = 4'b0011;
    errs = 0;
    for (int i = 0; i < 24; i++) begin
      step();
`ifdef SEL4_RR_ARBITER_TIMEOUT_EN
      exp_o = (i / 8) % 2;
`else
      exp_o = 0;
`endif
      total++; if ({bus.gnt, bus.sel, bus.valid} !== owner_vec(exp_o))
        $display("FAIL timeout_cycle_%0d: got %h/%h want owner %0d", i, bus.gnt, bus.sel, exp_o); else passed++;
    end
    bus.req = 4'h0;
    step();
  endtask

  task automatic test_tie();
    do_reset();
    bus.din = 4'h0;
    bus.req = 4'b0011;
    for (int i = 0; i < 8; i++) step();
    total++; if ({bus.gnt, bus.sel, bus.valid} !== owner_vec(0))
      $display("FAIL tie_before: got %h/%h want 1/0", bus.gnt, bus.sel); else passed++;
    bus.req = 4'b0110;
    step();
    total++; if ({bus.gnt, bus.sel, bus.valid} !== owner_vec(1))
      $display("FAIL tie_handover: got %h/%h want 2/1", bus.gnt, bus.sel); else passed++;
    bus.req = 4'b0010;
    step();
    total++; if ({bus.gnt, bus.sel, bus.valid} !== owner_vec(1))
      $display("FAIL tie_after: got %h/%h want 2/1", bus.gnt, bus.sel); else passed++;
    bus.req = 4'h0;
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req = 4'b0010;
    bus.din = 4'b0010;
    step();
    total++; if ({bus.gnt, bus.sel, bus.valid, bus.dout} !== {owner_vec(1), 1'b1})
      $display("FAIL areset_pre: got %h/%h/%b/%b want 2/1/1/1", bus.gnt, bus.sel, bus.valid, bus.dout); else passed++;
    rst = 1'b1;
    #1;
    total++; if ({bus.gnt, bus.sel, bus.valid, bus.dout} !== 8'h00)
      $display("FAIL areset_clear: got %h/%h/%b/%b want 0/0/0/0", bus.gnt, bus.sel, bus.valid, bus.dout); else passed++;
    #1;
    rst = 1'b0;
    step();
    total++; if ({bus.gnt, bus.sel, bus.valid, bus.dout} !== {owner_vec(1), 1'b1})
      $display("FAIL areset_regrant: got %h/%h/%b/%b want 2/1/1/1", bus.gnt, bus.sel, bus.valid, bus.dout); else passed++;
    bus.req = 4'h0;
    step();
  endtask

  initial begin
    bus.req = 4'h0;
    bus.din = 4'h0;
    test_reset();
    test_single();
    test_rr_order();
    test_wrap();
    test_timeout();
    test_tie();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
